// File: rtl/cache_packet_responder.sv
// Memory-side responder that services unified-cache request packets from a small block RAM.
// Optional feature macro: CACHE_PACKET_RESPONDER_WRITE_ACK_EN (writes also return an is_write=1 packet).
//
// state    | meaning
// S_IDLE   | waiting for any request valid, round-robin pick
// S_ACCEPT | one-cycle ack to the chosen way, port field checked
// S_WAIT   | fixed response latency
// S_EXEC   | RAM access, return packet built
// S_RESP   | return packet held until acked or timed out

`ifndef CPU_ADDR_LEN_IN_BITS
`define CPU_ADDR_LEN_IN_BITS 32
`endif
`ifndef UNIFIED_CACHE_BLOCK_SIZE_IN_BITS
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BITS 128
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 0
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI 31
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 32
`define UNIFIED_CACHE_PACKET_DATA_POS_HI 159
`define UNIFIED_CACHE_PACKET_TYPE_POS_LO 160
`define UNIFIED_CACHE_PACKET_TYPE_POS_HI 161
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO 162
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI 177
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 178
`define UNIFIED_CACHE_PACKET_PORT_NUM_HI 179
`define UNIFIED_CACHE_PACKET_VALID_POS 180
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 181
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS 182
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 183
`endif

module cache_packet_responder #(
    parameter int NUM_WAY          = 2,
    parameter int NUM_ENTRY        = 16,
    parameter int RESP_LATENCY     = 4,
    parameter int TIMING_OUT_CYCLE = 100000
) (
    input  logic                                                  clk_in,
    input  logic                                                  reset_in,
    input  logic [`UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_WAY-1:0] request_packet_flatted_in,
    output logic [NUM_WAY-1:0]                                    request_packet_ack_flatted_out,
    output logic [`UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_WAY-1:0] return_packet_flatted_out,
    input  logic [NUM_WAY-1:0]                                    return_packet_ack_flatted_in,
    output logic                                                  busy,
    output logic                                                  error
);

    localparam int PKT          = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int BLK          = `UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;
    localparam int NBYTE        = BLK / 8;
    localparam int OFF_W        = $clog2(NBYTE);
    localparam int IDX_W        = $clog2(NUM_ENTRY);
    localparam int WAY_W        = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
    localparam int WAIT_W       = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam int TO_W         = ($clog2(TIMING_OUT_CYCLE + 1) > 16) ? $clog2(TIMING_OUT_CYCLE + 1) : 16;
    localparam int ADDR_LO      = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
    localparam int DATA_LO      = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
    localparam int MASK_LO      = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO;
    localparam int PORT_LO      = `UNIFIED_CACHE_PACKET_PORT_NUM_LO;
    localparam int PORT_W       = `UNIFIED_CACHE_PACKET_PORT_NUM_HI - `UNIFIED_CACHE_PACKET_PORT_NUM_LO + 1;
    localparam int VALID_POS    = `UNIFIED_CACHE_PACKET_VALID_POS;
    localparam int IS_WRITE_POS = `UNIFIED_CACHE_PACKET_IS_WRITE_POS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PKT-1:0]     req_pkt [NUM_WAY];
    logic [NUM_WAY-1:0] req_valid;
    logic               pick_found;
    logic [WAY_W-1:0]   pick_way;
    logic [WAY_W-1:0]   cand;
    logic [PKT-1:0]     req_q;
    logic [PKT-1:0]     resp_q;
    logic [PKT-1:0]     resp_build;
    logic [WAY_W-1:0]   way_q;
    logic [WAY_W-1:0]   rr_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               error_q;
    logic [BLK-1:0]     ram [NUM_ENTRY];
    logic [IDX_W-1:0]   idx;
    logic [BLK-1:0]     rd_data;
    logic [BLK-1:0]     wr_data;
    logic [BLK-1:0]     merged;
    logic [NBYTE-1:0]   wr_mask;
    logic               is_wr;
    logic               ret_ack_sel;
    logic               resp_needed;

    for (genvar i = 0; i < NUM_WAY; i++) begin : g_way
        assign req_pkt[i]   = request_packet_flatted_in[i*PKT +: PKT];
        assign req_valid[i] = req_pkt[i][VALID_POS];
        assign request_packet_ack_flatted_out[i] = (state_q == S_ACCEPT) && (way_q == WAY_W'(i));
        assign return_packet_flatted_out[i*PKT +: PKT] =
            ((state_q == S_RESP) && (way_q == WAY_W'(i))) ? resp_q : '0;
    end

    assign busy  = (state_q != S_IDLE);
    assign error = error_q;

    // Lowest way index at or above the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_way   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_WAY; i++) begin
            cand = WAY_W'((int'(rr_q) + i) % NUM_WAY);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_way   = cand;
            end
        end
    end

    assign idx         = req_q[ADDR_LO + OFF_W +: IDX_W];
    assign rd_data     = ram[idx];
    assign wr_data     = req_q[DATA_LO +: BLK];
    assign wr_mask     = req_q[MASK_LO +: NBYTE];
    assign is_wr       = req_q[IS_WRITE_POS];
    assign ret_ack_sel = return_packet_ack_flatted_in[way_q];

    always_comb begin
        merged = rd_data;
        for (int b = 0; b < NBYTE; b++) begin
            if (wr_mask[b]) begin
                merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

`ifdef CACHE_PACKET_RESPONDER_WRITE_ACK_EN
    assign resp_needed = 1'b1;
`else
    assign resp_needed = !is_wr;
`endif

    always_comb begin
        resp_build            = req_q;
        resp_build[VALID_POS] = 1'b1;
`ifdef CACHE_PACKET_RESPONDER_WRITE_ACK_EN
        if (is_wr) begin
            resp_build[DATA_LO +: BLK] = merged;
        end else begin
            resp_build[IS_WRITE_POS]     = 1'b0;
            resp_build[DATA_LO +: BLK]   = rd_data;
            resp_build[MASK_LO +: NBYTE] = '0;
        end
`else
        resp_build[IS_WRITE_POS]     = 1'b0;
        resp_build[DATA_LO +: BLK]   = rd_data;
        resp_build[MASK_LO +: NBYTE] = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pick_found) state_d = S_ACCEPT;
            S_ACCEPT: state_d = (RESP_LATENCY == 0) ? S_EXEC : S_WAIT;
            S_WAIT:   if (wait_cnt_q == '0) state_d = S_EXEC;
            S_EXEC:   state_d = resp_needed ? S_RESP : S_IDLE;
            S_RESP:   if (ret_ack_sel || (to_cnt_q == '0)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            req_q      <= '0;
            resp_q     <= '0;
            way_q      <= '0;
            rr_q       <= '0;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            error_q    <= 1'b0;
            for (int e = 0; e < NUM_ENTRY; e++) begin
                ram[e] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        req_q <= req_pkt[pick_way];
                        way_q <= pick_way;
                    end
                end
                S_ACCEPT: begin
                    rr_q       <= WAY_W'((int'(way_q) + 1) % NUM_WAY);
                    wait_cnt_q <= WAIT_W'((RESP_LATENCY > 0) ? (RESP_LATENCY - 1) : 0);
                    if (int'(req_q[PORT_LO +: PORT_W]) != int'(way_q)) begin
                        error_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_wr) begin
                        ram[idx] <= merged;
                    end
                    resp_q   <= resp_build;
                    to_cnt_q <= TO_W'(TIMING_OUT_CYCLE);
                end
                S_RESP: begin
                    // Down-counter stops at zero; reaching it unacked is the timeout.
                    if (!ret_ack_sel) begin
                        if (to_cnt_q == '0) begin
                            error_q <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
